// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with XOR/XNOR feedback, multi-step advance, seed load, wrap/lockup flags.
// Optional LFSR_LOCKUP_RECOVERY_EN: enabled stepping out of the lockup state jumps back to SEED.
module lfsr_gen #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] TAPS          = WIDTH'(8'hB8),
  parameter bit               FEEDBACK_XNOR = 1'b0,
  parameter logic [WIDTH-1:0] SEED          = WIDTH'(1),
  parameter int               STEPS         = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             lockup
);

  // XOR feedback is stuck at all-zeros, XNOR feedback at all-ones.
  localparam logic [WIDTH-1:0] LOCK_STATE = {WIDTH{FEEDBACK_XNOR}};

`ifdef LFSR_LOCKUP_RECOVERY_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
    logic fb;
    fb = (^(s & TAPS)) ^ FEEDBACK_XNOR;
    return {s[WIDTH-2:0], fb};
  endfunction

  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;

  // STEPS single shifts unrolled so any STEPS completes in one clock.
  always_comb begin
    step_val = out;
    for (int i = 0; i < STEPS; i++) begin
      step_val = shift1(step_val);
    end
  end

  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
    if (load) begin
      out_nxt = load_value;
    end else if (enable) begin
      if (RECOVER && (out == LOCK_STATE)) begin
        out_nxt = SEED;
      end else begin
        out_nxt  = step_val;
        wrap_nxt = (step_val == SEED);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out    <= SEED;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else begin
      out    <= out_nxt;
      wrap   <= wrap_nxt;
      lockup <= (out_nxt == LOCK_STATE);
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three parameterisations driven in lockstep, scoreboard of expected out/wrap/lockup.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] dout  [3];
  logic       dwrap [3];
  logic       dlock [3];

  always #5 clk = ~clk;

  lfsr_gen u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .out(dout[0]), .wrap(dwrap[0]), .lockup(dlock[0])
  );

  lfsr_gen #(.STEPS(2)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .out(dout[1]), .wrap(dwrap[1]), .lockup(dlock[1])
  );

  lfsr_gen #(.STEPS(2), .FEEDBACK_XNOR(1'b1), .SEED(8'h00)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .out(dout[2]), .wrap(dwrap[2]), .lockup(dlock[2])
  );

`ifdef LFSR_LOCKUP_RECOVERY_EN
  localparam bit RECOV = 1'b1;
`else
  localparam bit RECOV = 1'b0;
`endif

  localparam logic [7:0] TB_TAPS = 8'hB8;

  int         lsteps [3] = '{1, 2, 2};
  bit         lxn    [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] lseed  [3] = '{8'h01, 8'h01, 8'h00};

  typedef struct packed {
    logic [2:0][7:0] o;
    logic [2:0]      w;
    logic [2:0]      l;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] ms [3];
  logic       mw [3];
  logic       ml [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference shift: walk the tap mask bit by bit.
  function automatic logic [7:0] shift_ref(input logic [7:0] s, input bit xn);
    logic fb;
    fb = xn;
    for (int i = 0; i < 8; i++) if (TB_TAPS[i]) fb = fb ^ s[i];
    return {s[6:0], fb};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ms[k] = lseed[k];
      mw[k] = 1'b0;
      ml[k] = 1'b0;
    end
  endtask

  task automatic step(input logic ld, input logic [7:0] lv, input logic en);
    exp_t       e;
    exp_t       got;
    logic [7:0] lock;
    logic [7:0] n;
    load       = ld;
    load_value = lv;
    enable     = en;
    for (int k = 0; k < 3; k++) begin
      lock = {8{lxn[k]}};
      if (ld) begin
        ms[k] = lv;
        mw[k] = 1'b0;
      end else if (en) begin
        if (RECOV && ms[k] == lock) begin
          ms[k] = lseed[k];
          mw[k] = 1'b0;
        end else begin
          n = ms[k];
          for (int j = 0; j < lsteps[k]; j++) n = shift_ref(n, lxn[k]);
          mw[k] = (n == lseed[k]);
          ms[k] = n;
        end
      end else begin
        mw[k] = 1'b0;
      end
      ml[k] = (ms[k] == lock);
      e.o[k] = ms[k];
      e.w[k] = mw[k];
      e.l[k] = ml[k];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      got.o[k] = dout[k];
      got.w[k] = dwrap[k];
      got.l[k] = dlock[k];
      check($sformatf("out%0d", k), got.o[k], e.o[k]);
      check($sformatf("wrap%0d", k), got.w[k], e.w[k]);
      check($sformatf("lockup%0d", k), got.l[k], e.l[k]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_out%0d", tag, k), dout[k], lseed[k]);
      check($sformatf("%s_wrap%0d", tag, k), dwrap[k], 1'b0);
      check($sformatf("%s_lock%0d", tag, k), dlock[k], 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] t1_exp [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
  logic [255:0] seen;
  int distinct;
  int wraps;

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    load       = 1'b0;
    load_value = 8'h00;
    model_reset();
    #12;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b1;

    // Basic single-step sequence from SEED.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check($sformatf("t1_seq%0d", i), dout[0], t1_exp[i]);
    end

    // Asynchronous reset mid-run while load and enable are both high.
    enable     = 1'b1;
    load       = 1'b1;
    load_value = 8'h77;
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_state("async");
    @(posedge clk);
    #1;
    check_reset_state("held");
    enable = 1'b0;
    load   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    check("resume", dout[0], 8'h02);

    // Full period: 255 enables from SEED.
    do_reset();
    seen     = '0;
    distinct = 0;
    wraps    = 0;
    for (int i = 0; i < 255; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (dout[0] != 8'h00 && !seen[dout[0]]) distinct++;
      seen[dout[0]] = 1'b1;
      if (dwrap[0]) wraps++;
    end
    check("period_out", dout[0], 8'h01);
    check("period_wrap", dwrap[0], 1'b1);
    check("period_distinct", distinct, 255);
    check("period_wrapcount", wraps, 1);
    step(1'b0, 8'h00, 1'b1);
    check("period_wrap_drop", dwrap[0], 1'b0);

    // Multi-step and XNOR variants.
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    check("steps2_a", dout[1], 8'h04);
    check("xnor_a", dout[2], 8'h03);
    step(1'b0, 8'h00, 1'b1);
    check("steps2_b", dout[1], 8'h11);

    // Load has priority over enable and never raises wrap.
    step(1'b1, 8'h5A, 1'b1);
    check("load5a", dout[0], 8'h5A);
    check("load5a_wrap", dwrap[0], 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("after5a", dout[0], 8'hB4);
    step(1'b1, 8'h01, 1'b0);
    check("loadseed_wrap", dwrap[0], 1'b0);
    step(1'b1, 8'h01, 1'b1);
    check("loadseed_en_wrap", dwrap[0], 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("hold", dout[0], 8'h01);

    // Lockup state.
    step(1'b1, 8'h00, 1'b0);
    check("lock_load", dlock[0], 1'b1);
    check("lock_xnor_load", dlock[2], 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("lock_en1_out", dout[0], RECOV ? 8'h01 : 8'h00);
    check("lock_en1_flag", dlock[0], RECOV ? 1'b0 : 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("lock_en3_flag", dlock[0], RECOV ? 1'b0 : 1'b1);
    step(1'b1, 8'hFF, 1'b0);
    check("xnor_lock_load", dlock[2], 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("xnor_lock_en", dout[2], RECOV ? 8'h00 : 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
